// File: rtl/bitwave_pkg.sv
// Shared types and constants for the bit-column-serial weight scheduler.
// Lane arrays, FSM states and the sign-magnitude helper.
package bitwave_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int VEC_LENGTH    = 16;
  localparam int MAG_WIDTH     = DATA_WIDTH - 1;
  localparam int COL_IDX_WIDTH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] lane_data_t;
  typedef logic [VEC_LENGTH-1:0][MAG_WIDTH-1:0]  lane_mag_t;
  typedef logic [VEC_LENGTH-1:0]                 lane_bit_t;
  typedef logic [MAG_WIDTH-1:0]                  col_mask_t;

  // Magnitude of a two's complement value; -2^(N-1) saturates to all ones.
  function automatic col_mask_t to_mag(
    input logic [DATA_WIDTH-1:0] w
  );
    logic [DATA_WIDTH-1:0] neg;
    neg = ~w + DATA_WIDTH'(1);
    if (!w[DATA_WIDTH-1]) return w[MAG_WIDTH-1:0];
    if (neg[DATA_WIDTH-1]) return '1;
    return neg[MAG_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/bitwave_col_pick.sv
// Highest-set-bit picker over a column mask.
// Ports: mask_i in; idx_o, found_o, rest_o (mask with idx cleared) out.
module bitwave_col_pick
  import bitwave_pkg::*;
(
  input  logic [MAG_WIDTH-1:0]     mask_i,
  output logic [COL_IDX_WIDTH-1:0] idx_o,
  output logic                     found_o,
  output logic [MAG_WIDTH-1:0]     rest_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Ascending scan: the last hit wins, i.e. the highest set bit.
    for (int i = 0; i < MAG_WIDTH; i++) begin
      if (mask_i[i]) begin
        idx_o   = COL_IDX_WIDTH'(i);
        found_o = 1'b1;
      end
    end
    rest_o = mask_i & ~(MAG_WIDTH'(1) << idx_o);
  end

endmodule

// File: rtl/bitwave_col_scheduler.sv
// Column scheduler: captures a weight/activation group, converts weights to
// sign-magnitude and issues one nonzero magnitude column per cycle to the MAC.
// Ports: clk, reset; in_valid/in_ready/in_first, w_in, act_in (group input);
// act_out, sign_out, w_bit_out, column_idx_out, col_valid, col_last,
// en_out, load_accum_out (registered MAC-side outputs).
module bitwave_col_scheduler
  import bitwave_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  lane_data_t               w_in,
  input  lane_data_t               act_in,
  output lane_data_t               act_out,
  output lane_bit_t                sign_out,
  output lane_bit_t                w_bit_out,
  output logic [COL_IDX_WIDTH-1:0] column_idx_out,
  output logic                     col_valid,
  output logic                     col_last,
  output logic                     en_out,
  output logic                     load_accum_out
);

  state_t                   state_q, state_d;
  lane_data_t               act_q, act_d;
  lane_bit_t                sign_q, sign_d;
  lane_mag_t                mag_q, mag_d;
  col_mask_t                work_q, work_d;
  logic [COL_IDX_WIDTH-1:0] col_q, col_d;
  lane_bit_t                wbit_q, wbit_d;
  logic                     col_valid_q, col_valid_d;
  logic                     col_last_q, col_last_d;
  logic                     first_q, first_d;
  logic                     en_q, en_d;
  logic                     load_q, load_d;

  lane_mag_t                in_mag, mag_src;
  col_mask_t                in_mask, pick_mask, pick_rest;
  logic [COL_IDX_WIDTH-1:0] pick_idx;
  logic                     pick_found;
  logic                     accept, issue;

  assign in_ready = ~reset & ((state_q == IDLE) | col_last_q);
  assign accept   = in_valid & in_ready;

  always_comb begin
    in_mask = '0;
    for (int l = 0; l < VEC_LENGTH; l++) begin
      in_mag[l] = to_mag(w_in[l]);
      in_mask   = in_mask | in_mag[l];
    end
  end

  // One picker serves both the fresh group and the working mask.
  assign pick_mask = accept ? in_mask : work_q;
  assign mag_src   = accept ? in_mag  : mag_q;

  bitwave_col_pick u_pick (
    .mask_i  (pick_mask),
    .idx_o   (pick_idx),
    .found_o (pick_found),
    .rest_o  (pick_rest)
  );

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    work_d      = work_q;
    col_d       = '0;
    wbit_d      = '0;
    col_valid_d = 1'b0;
    col_last_d  = 1'b0;
    first_d     = 1'b0;
    issue       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: begin
        if (!col_last_q || accept) issue = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      act_d   = act_in;
      mag_d   = in_mag;
      first_d = in_first;
      for (int l = 0; l < VEC_LENGTH; l++)
        sign_d[l] = w_in[l][DATA_WIDTH-1];
    end

    // Empty mask falls through as a dummy column 0 with zero bits.
    if (issue) begin
      col_valid_d = 1'b1;
      col_d       = pick_idx;
      work_d      = pick_rest;
      col_last_d  = ~|pick_rest;
      for (int l = 0; l < VEC_LENGTH; l++)
        wbit_d[l] = pick_found & mag_src[l][pick_idx];
    end

    // Trailing enable drains the MAC psum; load lands with first psum.
    en_d   = col_valid_d | col_valid_q;
    load_d = first_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      act_q       <= '0;
      sign_q      <= '0;
      mag_q       <= '0;
      work_q      <= '0;
      col_q       <= '0;
      wbit_q      <= '0;
      col_valid_q <= 1'b0;
      col_last_q  <= 1'b0;
      first_q     <= 1'b0;
      en_q        <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      work_q      <= work_d;
      col_q       <= col_d;
      wbit_q      <= wbit_d;
      col_valid_q <= col_valid_d;
      col_last_q  <= col_last_d;
      first_q     <= first_d;
      en_q        <= en_d;
      load_q      <= load_d;
    end
  end

  assign act_out        = act_q;
  assign sign_out       = sign_q;
  assign w_bit_out      = wbit_q;
  assign column_idx_out = col_q;
  assign col_valid      = col_valid_q;
  assign col_last       = col_last_q;
  assign en_out         = en_q;
  assign load_accum_out = load_q;

endmodule

// File: tb/tb_bitwave_col_scheduler.sv
// Directed bench for bitwave_col_scheduler.
// Hand-computed expectations checked with immediate assertions.
module tb_bitwave_col_scheduler;
  import bitwave_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_first;
  lane_data_t               w_in;
  lane_data_t               act_in;
  lane_data_t               act_out;
  lane_bit_t                sign_out;
  lane_bit_t                w_bit_out;
  logic [COL_IDX_WIDTH-1:0] column_idx_out;
  logic                     col_valid;
  logic                     col_last;
  logic                     en_out;
  logic                     load_accum_out;

  int n_cmp = 0;
  int n_bad = 0;
  int acc;

  bitwave_col_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_first       (in_first),
    .w_in           (w_in),
    .act_in         (act_in),
    .act_out        (act_out),
    .sign_out       (sign_out),
    .w_bit_out      (w_bit_out),
    .column_idx_out (column_idx_out),
    .col_valid      (col_valid),
    .col_last       (col_last),
    .en_out         (en_out),
    .load_accum_out (load_accum_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Column outputs in one go: valid, last, index, bits.
  task automatic chk_col(input string tag, input logic v, input logic l,
                         input int idx, input logic [15:0] bits);
    chk({tag, ".valid"}, 128'(col_valid), 128'(v));
    chk({tag, ".last"}, 128'(col_last), 128'(l));
    chk({tag, ".idx"}, 128'(column_idx_out), 128'(idx));
    chk({tag, ".bits"}, 128'(w_bit_out), 128'(bits));
  endtask

  // Reference MAC: signed activation times weight bit, shifted by column.
  task automatic mac();
    if (col_valid)
      for (int l = 0; l < VEC_LENGTH; l++)
        if (w_bit_out[l]) begin
          if (sign_out[l]) acc -= int'($signed(act_out[l])) << column_idx_out;
          else             acc += int'($signed(act_out[l])) << column_idx_out;
        end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    w_in     = '0;
    act_in   = '0;
    step();
    step();
    chk("rst.ready", 128'(in_ready), 128'(0));
    chk_col("rst", 1'b0, 1'b0, 0, 16'h0);
    chk("rst.en", 128'(en_out), 128'(0));
    chk("rst.load", 128'(load_accum_out), 128'(0));
    chk("rst.act", act_out, 128'(0));
    chk("rst.sign", 128'(sign_out), 128'(0));
    reset = 1'b0;
    step();
    chk("rel.ready", 128'(in_ready), 128'(1));
    chk("rel.valid", 128'(col_valid), 128'(0));

    // Group 1: w=5 everywhere, act=3, new accumulation.
    acc = 0;
    in_valid = 1'b1;
    in_first = 1'b1;
    for (int l = 0; l < VEC_LENGTH; l++) begin
      w_in[l]   = 8'd5;
      act_in[l] = 8'd3;
    end
    step();
    in_valid = 1'b0;
    chk_col("g1.c2", 1'b1, 1'b0, 2, 16'hFFFF);
    chk("g1.c2.en", 128'(en_out), 128'(1));
    chk("g1.c2.load", 128'(load_accum_out), 128'(0));
    chk("g1.c2.ready", 128'(in_ready), 128'(0));
    chk("g1.act", act_out, {16{8'd3}});
    chk("g1.sign", 128'(sign_out), 128'(0));
    mac();
    step();
    chk_col("g1.c0", 1'b1, 1'b1, 0, 16'hFFFF);
    chk("g1.c0.en", 128'(en_out), 128'(1));
    chk("g1.c0.load", 128'(load_accum_out), 128'(1));
    chk("g1.c0.ready", 128'(in_ready), 128'(1));
    mac();
    step();
    chk("g1.drain.valid", 128'(col_valid), 128'(0));
    chk("g1.drain.en", 128'(en_out), 128'(1));
    chk("g1.drain.load", 128'(load_accum_out), 128'(0));
    chk("g1.acc", 128'(acc), 128'(240));
    step();
    chk("g1.idle.en", 128'(en_out), 128'(0));

    // Group 2: -1 on even lanes, +64 on odd lanes.
    in_valid = 1'b1;
    in_first = 1'b0;
    for (int l = 0; l < VEC_LENGTH; l++)
      w_in[l] = (l % 2 == 0) ? 8'hFF : 8'h40;
    step();
    in_valid = 1'b0;
    chk_col("g2.c6", 1'b1, 1'b0, 6, 16'hAAAA);
    chk("g2.sign", 128'(sign_out), 128'(16'h5555));
    step();
    chk_col("g2.c0", 1'b1, 1'b1, 0, 16'h5555);
    chk("g2.load", 128'(load_accum_out), 128'(0));
    step();
    chk("g2.drain.valid", 128'(col_valid), 128'(0));
    chk("g2.drain.load", 128'(load_accum_out), 128'(0));
    step();

    // Group 3: all-zero weights -> one dummy column.
    in_valid = 1'b1;
    w_in     = '0;
    step();
    in_valid = 1'b0;
    chk_col("g3.dummy", 1'b1, 1'b1, 0, 16'h0);
    chk("g3.ready", 128'(in_ready), 128'(1));
    step();
    chk("g3.after.valid", 128'(col_valid), 128'(0));
    chk("g3.after.en", 128'(en_out), 128'(1));
    step();

    // Group 4: -128 on lane 0 saturates to magnitude 127.
    in_valid = 1'b1;
    in_first = 1'b1;
    w_in     = '0;
    w_in[0]  = 8'h80;
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
    chk("g4.sign", 128'(sign_out), 128'(16'h0001));
    for (int c = 6; c >= 0; c--) begin
      chk_col($sformatf("g4.c%0d", c), 1'b1, c == 0, c, 16'h0001);
      chk($sformatf("g4.c%0d.load", c), 128'(load_accum_out),
          128'(c == 5));
      step();
    end
    chk("g4.end.valid", 128'(col_valid), 128'(0));
    step();

    // Back-to-back: mask 0b0000011 then 0b1000000, no bubble.
    in_valid = 1'b1;
    w_in     = '0;
    w_in[0]  = 8'd3;
    step();
    w_in    = '0;
    w_in[1] = 8'd64;
    chk_col("b2b.c1", 1'b1, 1'b0, 1, 16'h0001);
    chk("b2b.c1.ready", 128'(in_ready), 128'(0));
    step();
    chk_col("b2b.c0", 1'b1, 1'b1, 0, 16'h0001);
    chk("b2b.c0.ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    chk_col("b2b.c6", 1'b1, 1'b1, 6, 16'h0002);
    chk("b2b.c6.ready", 128'(in_ready), 128'(1));
    step();
    chk("b2b.end.valid", 128'(col_valid), 128'(0));
    step();

    // Reset during the column-0 cycle discards the group.
    in_valid = 1'b1;
    in_first = 1'b1;
    w_in     = '0;
    w_in[0]  = 8'd3;
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
    chk_col("rm.c1", 1'b1, 1'b0, 1, 16'h0001);
    step();
    chk_col("rm.c0", 1'b1, 1'b1, 0, 16'h0001);
    reset = 1'b1;
    #1;
    chk("rm.async.valid", 128'(col_valid), 128'(0));
    chk("rm.async.en", 128'(en_out), 128'(0));
    chk("rm.async.ready", 128'(in_ready), 128'(0));
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rm.q%0d.valid", k), 128'(col_valid), 128'(0));
      chk($sformatf("rm.q%0d.en", k), 128'(en_out), 128'(0));
      chk($sformatf("rm.q%0d.load", k), 128'(load_accum_out), 128'(0));
    end
    chk("rm.ready", 128'(in_ready), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
